// File: rtl/fifo_flex_pkg.sv
// Shared helpers for the fifo_flex valid/ready FIFO: depth and count-width derivation.
package fifo_flex_pkg;

  localparam int unsigned DEPTH_IDX_MIN = 32'd1;
  localparam int unsigned DEPTH_IDX_MAX = 32'd8;

  function automatic int unsigned depth_of(input int unsigned depth_idx);
    return 32'd1 << depth_idx;
  endfunction

  // Count must represent 0..DEPTH inclusive, hence one bit wider than a pointer.
  function automatic int unsigned cnt_w_of(input int unsigned depth_idx);
    return depth_idx + 32'd1;
  endfunction

endpackage

// File: rtl/fifo_flex_chk.sv
// Elaboration-time legality checks on the fifo_flex parameter set.
module fifo_flex_chk
  import fifo_flex_pkg::*;
#(
  parameter int DEPTH_IDX  = 2,
  parameter int AFULL_THR  = 3,
  parameter int AEMPTY_THR = 1
) ();

  localparam int DEPTH = int'(depth_of(DEPTH_IDX));

  if ((DEPTH_IDX < int'(DEPTH_IDX_MIN)) || (DEPTH_IDX > int'(DEPTH_IDX_MAX))) begin : g_bad_depth
    $error("fifo_flex: DEPTH_IDX out of range 1..8");
  end

  if ((AFULL_THR < 1) || (AFULL_THR > DEPTH)) begin : g_bad_afull
    $error("fifo_flex: AFULL_THR out of range 1..DEPTH");
  end

  if ((AEMPTY_THR < 0) || (AEMPTY_THR > (DEPTH - 1))) begin : g_bad_aempty
    $error("fifo_flex: AEMPTY_THR out of range 0..DEPTH-1");
  end

endmodule

// File: rtl/fifo_flex_ctrl.sv
// Pointer, occupancy and status-flag control for fifo_flex; flush clears all state.
module fifo_flex_ctrl
  import fifo_flex_pkg::*;
#(
  parameter int DEPTH_IDX  = 2,
  parameter int AFULL_THR  = 3,
  parameter int AEMPTY_THR = 1,
  localparam int CNT_W     = int'(cnt_w_of(DEPTH_IDX))
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 flush_i,
  input  logic                 push_i,
  input  logic                 pop_i,
  output logic [DEPTH_IDX-1:0] wr_ptr_o,
  output logic [DEPTH_IDX-1:0] rd_ptr_o,
  output logic [CNT_W-1:0]     count_o,
  output logic                 in_rdy_o,
  output logic                 out_val_o,
  output logic                 almost_full_o,
  output logic                 almost_empty_o
);

  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(depth_of(DEPTH_IDX));

  logic [DEPTH_IDX-1:0] wr_ptr_q, wr_ptr_d;
  logic [DEPTH_IDX-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]     count_q, count_d;

  // Next-state: pointers wrap naturally; push/pop are pre-qualified so count stays in 0..DEPTH.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = {DEPTH_IDX{1'b0}};
      rd_ptr_d = {DEPTH_IDX{1'b0}};
      count_d  = {CNT_W{1'b0}};
    end else begin
      if (push_i) begin
        wr_ptr_d = wr_ptr_q + DEPTH_IDX'(1);
      end else begin
        wr_ptr_d = wr_ptr_q;
      end
      if (pop_i) begin
        rd_ptr_d = rd_ptr_q + DEPTH_IDX'(1);
      end else begin
        rd_ptr_d = rd_ptr_q;
      end
      case ({push_i, pop_i})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= {DEPTH_IDX{1'b0}};
      rd_ptr_q <= {DEPTH_IDX{1'b0}};
      count_q  <= {CNT_W{1'b0}};
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign wr_ptr_o       = wr_ptr_q;
  assign rd_ptr_o       = rd_ptr_q;
  assign count_o        = count_q;
  assign in_rdy_o       = (count_q != DEPTH_C) & ~flush_i;
  assign out_val_o      = (count_q != {CNT_W{1'b0}}) & ~flush_i;
  assign almost_full_o  = (count_q >= CNT_W'(AFULL_THR));
  assign almost_empty_o = (count_q <= CNT_W'(AEMPTY_THR));

endmodule

// File: rtl/fifo_flex.sv
// Valid/ready FIFO with occupancy count, almost flags and flush.
// Optional same-cycle empty bypass enabled by defining FIFO_FLEX_BYPASS_EN.
module fifo_flex
  import fifo_flex_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter int DEPTH_IDX  = 2,
  parameter int AFULL_THR  = 3,
  parameter int AEMPTY_THR = 1,
  localparam int CNT_W     = int'(cnt_w_of(DEPTH_IDX)),
  localparam int DEPTH     = int'(depth_of(DEPTH_IDX))
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_val,
  output logic              in_rdy,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_val,
  input  logic              out_rdy,
  output logic [DATA_W-1:0] out_data,
  input  logic              flush,
  output logic [CNT_W-1:0]  count,
  output logic              almost_full,
  output logic              almost_empty
);

  logic [DATA_W-1:0]    mem_q [DEPTH];
  logic [DEPTH_IDX-1:0] wr_ptr_s;
  logic [DEPTH_IDX-1:0] rd_ptr_s;
  logic                 fifo_val_s;
  logic                 pass_s;
  logic                 in_hsk_s;
  logic                 out_hsk_s;
  logic                 push_s;
  logic                 pop_s;

  fifo_flex_chk #(
    .DEPTH_IDX  (DEPTH_IDX),
    .AFULL_THR  (AFULL_THR),
    .AEMPTY_THR (AEMPTY_THR)
  ) u_chk ();

  fifo_flex_ctrl #(
    .DEPTH_IDX  (DEPTH_IDX),
    .AFULL_THR  (AFULL_THR),
    .AEMPTY_THR (AEMPTY_THR)
  ) u_ctrl (
    .clk            (clk),
    .rst_n          (rst_n),
    .flush_i        (flush),
    .push_i         (push_s),
    .pop_i          (pop_s),
    .wr_ptr_o       (wr_ptr_s),
    .rd_ptr_o       (rd_ptr_s),
    .count_o        (count),
    .in_rdy_o       (in_rdy),
    .out_val_o      (fifo_val_s),
    .almost_full_o  (almost_full),
    .almost_empty_o (almost_empty)
  );

`ifdef FIFO_FLEX_BYPASS_EN
  logic empty_s;
  assign empty_s  = (count == {CNT_W{1'b0}});
  // A word offered to an empty FIFO with a ready consumer skips storage entirely.
  assign pass_s   = empty_s & ~flush & in_val & out_rdy;
  assign out_val  = empty_s ? (in_val & ~flush) : fifo_val_s;
  assign out_data = empty_s ? in_data : mem_q[rd_ptr_s];
`else
  assign pass_s   = 1'b0;
  assign out_val  = fifo_val_s;
  assign out_data = mem_q[rd_ptr_s];
`endif

  assign in_hsk_s  = in_val & in_rdy;
  assign out_hsk_s = out_val & out_rdy;
  assign push_s    = in_hsk_s & ~pass_s;
  assign pop_s     = out_hsk_s & ~pass_s;

  // Storage write; contents are intentionally not reset.
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_q[wr_ptr_s] <= in_data;
    end
  end

endmodule
